frv_mem_arbiter: RTL and testbench
==================================

Name: frv_mem_arbiter

Overview:
- Shares one memory bus port between the instruction fetch port and the data load/store port of the core.
- Uses the core's req/gnt request phase and recv/ack response phase protocol on all three ports.
- Arbitrates request phases and tracks outstanding requests in an in-order owner FIFO, so each response returns to the requester that issued it.
- Sits between the fetch/LSU pipeline stages and the single external memory interface.

Parameters:
- XL, 31, MSB index of address/data buses (buses are XL+1 = 32 bits).
- MAX_OUTSTANDING, 2, owner FIFO depth (1..4): maximum granted-but-unresponded requests.
- MAX_D_STREAK, 4, consecutive data grants allowed while an instruction request is waiting.

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  reset. One clock; reset is asynchronous and active-high.
- i_req  in  1  instruction port request.
- i_wen  in  1  instruction port write enable.
- i_strb  in  4  instruction port write strobe.
- i_wdata  in  32  instruction port write data.
- i_addr  in  32  instruction port address.
- i_gnt  out  1  instruction request accepted.
- i_recv  out  1  instruction response valid.
- i_ack  in  1  instruction port accepts response.
- d_req, d_wen, d_strb, d_wdata, d_addr, d_gnt, d_recv, d_ack: same as the i_ signals, for the data port.
- m_req  out  1  memory request.
- m_wen  out  1  memory write enable.
- m_strb  out  4  memory write strobe.
- m_wdata  out  32  memory write data.
- m_addr  out  32  memory address.
- m_gnt  in  1  memory accepted request.
- m_recv  in  1  memory response valid.
- m_ack  out  1  response accepted.
- m_error  in  1  response error.
- m_rdata  in  32  response data.
- rsp_error  out  1  response error, broadcast to both ports.
- rsp_rdata  out  32  response data, broadcast to both ports.
- outstanding  out  3  current owner FIFO occupancy.

Behaviour:
- State: sel (0 = instr, 1 = data), locked, streak[2:0], owner FIFO (1 bit per entry, MAX_OUTSTANDING entries), count[2:0].
- Reset (async, g_reset = 1): sel = 0, locked = 0, streak = 0, FIFO empty, count = 0.
  - Hence outstanding = 0, m_req = 0, i_gnt = d_gnt = 0, i_recv = d_recv = 0, m_ack = 0.
  - Reset mid-transaction discards all tracking. Late memory responses after reset are handled by the empty-FIFO rule below.
- full = (count == MAX_OUTSTANDING); empty = (count == 0).

Arbitration (combinational winner, registered lock):
- If locked: winner = sel.
- Else if i_req && d_req: winner = instr if streak == MAX_D_STREAK, otherwise data.
- Else winner = whichever requester is asserting. If neither, winner = sel.
- m_req = winner's req && !full. m_wen/m_strb/m_wdata/m_addr mux from the winner.
- i_gnt = m_gnt && m_req && winner == instr. d_gnt is the same for data. The loser's gnt is always 0.
- Next cycle: sel <= winner; locked <= m_req && !m_gnt. A stalled request keeps its slot until granted, so m_addr stays stable. Requesters must hold req/addr until gnt.
- streak:
  - data grant while i_req is high: streak + 1, saturating at MAX_D_STREAK.
  - instruction grant: 0.
  - otherwise: hold.
- Full: m_req = 0 even if a pop occurs in the same cycle. There is no push while full.

Response routing:
- head = FIFO head owner.
- i_recv = m_recv && !empty && head == instr. d_recv is the same for data.
- m_ack = empty ? 0 : (head == instr ? i_ack : d_ack).
- rsp_rdata = m_rdata and rsp_error = m_error, unconditionally.
- m_recv while empty: no recv asserted, m_ack = 0, no state change.

FIFO update:
- push = m_req && m_gnt, writing winner. pop = m_recv && m_ack.
- Simultaneous push and pop: count unchanged, head advances, new entry written at tail.
- Pointers wrap modulo MAX_OUTSTANDING.
- outstanding = count.

Latency:
- Zero-cycle combinational pass-through for request and response.
- No added cycles when there is no contention.

Test Plan:
- Reset, then i_req=1, i_addr=0x80000000, m_gnt=1 -> m_req=1, m_addr=0x80000000, i_gnt=1, outstanding=1 next cycle. Then m_recv=1, i_ack=1, m_rdata=0x00000013 -> i_recv=1, rsp_rdata=0x13, outstanding=0.
- i_req and d_req held with m_gnt=1 every cycle, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- d_req=1 with m_gnt=0 for 3 cycles, i_req rising in cycle 2 -> m_addr stays at d_addr, i_gnt=0 until d_gnt pulses in cycle 4.
- Issue I then D (MAX_OUTSTANDING=2), third request pending -> m_req=0 while outstanding=2. First response routes to i_recv, second to d_recv. The third request is granted the cycle after the first pop.
- m_recv=1 with the FIFO empty -> i_recv=d_recv=0, m_ack=0, outstanding stays 0.
- Assert g_reset asynchronously with outstanding=2 -> outstanding=0 immediately. A following m_recv gives no recv and no ack.

Source files
------------

// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter
// Shares one memory bus port between the instruction fetch port (i_*) and
// the data load/store port (d_*). Request phases are arbitrated with a
// bounded data-priority streak; granted requests are recorded in an
// in-order owner FIFO so each memory response is steered back to the port
// that issued it.
//
// Ports:
//   g_clk, g_reset                 clock, asynchronous active-high reset
//   i_req/i_wen/i_strb/i_wdata/i_addr, i_gnt, i_recv, i_ack   instruction port
//   d_req/d_wen/d_strb/d_wdata/d_addr, d_gnt, d_recv, d_ack   data port
//   m_req/m_wen/m_strb/m_wdata/m_addr, m_gnt, m_recv, m_ack,
//   m_error, m_rdata                                          memory port
//   rsp_error, rsp_rdata          response broadcast to both requesters
//   outstanding                   current owner FIFO occupancy
module frv_mem_arbiter #(
  parameter int XL              = 31,
  parameter int MAX_OUTSTANDING = 2,
  parameter int MAX_D_STREAK    = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        i_req,
  input  logic        i_wen,
  input  logic [3:0]  i_strb,
  input  logic [XL:0] i_wdata,
  input  logic [XL:0] i_addr,
  output logic        i_gnt,
  output logic        i_recv,
  input  logic        i_ack,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [3:0]  d_strb,
  input  logic [XL:0] d_wdata,
  input  logic [XL:0] d_addr,
  output logic        d_gnt,
  output logic        d_recv,
  input  logic        d_ack,
  output logic        m_req,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [XL:0] m_wdata,
  output logic [XL:0] m_addr,
  input  logic        m_gnt,
  input  logic        m_recv,
  output logic        m_ack,
  input  logic        m_error,
  input  logic [XL:0] m_rdata,
  output logic        rsp_error,
  output logic [XL:0] rsp_rdata,
  output logic [2:0]  outstanding
);

  localparam logic [2:0] DEPTH_C      = 3'(MAX_OUTSTANDING);
  localparam logic [2:0] STREAK_MAX_C = 3'(MAX_D_STREAK);
  localparam logic [1:0] PTR_LAST_C   = 2'(MAX_OUTSTANDING - 1);

  // Owner encoding: 0 = instruction port, 1 = data port.
  logic       sel_r;
  logic       locked_r;
  logic [2:0] streak_r;
  logic [3:0] owner_r;
  logic [1:0] head_ptr_r;
  logic [1:0] tail_ptr_r;
  logic [2:0] count_r;

  logic winner_s;
  logic full_s;
  logic empty_s;
  logic head_s;
  logic push_s;
  logic pop_s;

  // Pointers wrap at the configured FIFO depth, not at the 2-bit range.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    if (p == PTR_LAST_C) begin
      return 2'd0;
    end else begin
      return p + 2'd1;
    end
  endfunction

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == 3'd0);
  assign head_s  = owner_r[head_ptr_r];

  // Winner selection: a stalled request keeps its slot; otherwise data wins
  // contention until the streak limit lets a waiting fetch through.
  always_comb begin
    winner_s = sel_r;
    if (locked_r) begin
      winner_s = sel_r;
    end else if (i_req && d_req) begin
      winner_s = (streak_r == STREAK_MAX_C) ? 1'b0 : 1'b1;
    end else if (i_req) begin
      winner_s = 1'b0;
    end else if (d_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = sel_r;
    end
  end

  // Request-phase mux towards memory and grant fan-back.
  always_comb begin
    m_req   = 1'b0;
    m_wen   = 1'b0;
    m_strb  = 4'd0;
    m_wdata = '0;
    m_addr  = '0;
    if (winner_s) begin
      m_req   = d_req && !full_s;
      m_wen   = d_wen;
      m_strb  = d_strb;
      m_wdata = d_wdata;
      m_addr  = d_addr;
    end else begin
      m_req   = i_req && !full_s;
      m_wen   = i_wen;
      m_strb  = i_strb;
      m_wdata = i_wdata;
      m_addr  = i_addr;
    end
  end

  assign i_gnt  = m_gnt && m_req && !winner_s;
  assign d_gnt  = m_gnt && m_req &&  winner_s;

  // Responses with nothing outstanding are ignored: no recv, no ack.
  assign i_recv = m_recv && !empty_s && !head_s;
  assign d_recv = m_recv && !empty_s &&  head_s;
  assign m_ack  = empty_s ? 1'b0 : (head_s ? d_ack : i_ack);

  assign rsp_rdata   = m_rdata;
  assign rsp_error   = m_error;
  assign outstanding = count_r;

  assign push_s = m_req && m_gnt;
  assign pop_s  = m_recv && m_ack;

  // Arbitration state, streak counter and owner FIFO.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      sel_r      <= 1'b0;
      locked_r   <= 1'b0;
      streak_r   <= 3'd0;
      owner_r    <= 4'd0;
      head_ptr_r <= 2'd0;
      tail_ptr_r <= 2'd0;
      count_r    <= 3'd0;
    end else begin
      sel_r    <= winner_s;
      locked_r <= m_req && !m_gnt;

      if (push_s && winner_s && i_req) begin
        if (streak_r != STREAK_MAX_C) begin
          streak_r <= streak_r + 3'd1;
        end
      end else if (push_s && !winner_s) begin
        streak_r <= 3'd0;
      end

      if (push_s) begin
        owner_r[tail_ptr_r] <= winner_s;
        tail_ptr_r          <= ptr_next(tail_ptr_r);
      end
      if (pop_s) begin
        head_ptr_r <= ptr_next(head_ptr_r);
      end

      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
module tb_frv_mem_arbiter;

  logic        g_clk;
  logic        g_reset;
  logic        i_req, i_wen, i_ack, d_req, d_wen, d_ack;
  logic [3:0]  i_strb, d_strb;
  logic [31:0] i_wdata, i_addr, d_wdata, d_addr;
  logic        i_gnt, i_recv, d_gnt, d_recv;
  logic        m_req, m_wen, m_gnt, m_recv, m_ack, m_error;
  logic [3:0]  m_strb;
  logic [31:0] m_wdata, m_addr, m_rdata;
  logic        rsp_error;
  logic [31:0] rsp_rdata;
  logic [2:0]  outstanding;

  int checks;
  int failures;

  frv_mem_arbiter #(.XL(31), .MAX_OUTSTANDING(2), .MAX_D_STREAK(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .i_req(i_req), .i_wen(i_wen), .i_strb(i_strb), .i_wdata(i_wdata), .i_addr(i_addr),
    .i_gnt(i_gnt), .i_recv(i_recv), .i_ack(i_ack),
    .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_wdata(d_wdata), .d_addr(d_addr),
    .d_gnt(d_gnt), .d_recv(d_recv), .d_ack(d_ack),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata), .m_addr(m_addr),
    .m_gnt(m_gnt), .m_recv(m_recv), .m_ack(m_ack), .m_error(m_error), .m_rdata(m_rdata),
    .rsp_error(rsp_error), .rsp_rdata(rsp_rdata), .outstanding(outstanding)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 1'b0; i_wen = 1'b0; i_strb = 4'h0; i_wdata = 32'h0; i_addr = 32'h0; i_ack = 1'b0;
    d_req = 1'b0; d_wen = 1'b0; d_strb = 4'h0; d_wdata = 32'h0; d_addr = 32'h0; d_ack = 1'b0;
    m_gnt = 1'b0; m_recv = 1'b0; m_error = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    g_reset = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge g_clk);
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding);
    end
    checks++;
    if ({m_req, i_gnt, d_gnt, i_recv, d_recv, m_ack} !== 6'b000000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=000000", {m_req, i_gnt, d_gnt, i_recv, d_recv, m_ack});
    end
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_basic();
    i_req = 1'b1; i_addr = 32'h8000_0000; m_gnt = 1'b1;
    @(negedge g_clk);
    checks++;
    if ({m_req, i_gnt, d_gnt} !== 3'b110) begin
      failures++; $display("FAIL basic_req_gnt got=%b exp=110", {m_req, i_gnt, d_gnt});
    end
    checks++;
    if (m_addr !== 32'h8000_0000) begin
      failures++; $display("FAIL basic_m_addr got=%h exp=80000000", m_addr);
    end
    next_cycle();
    i_req = 1'b0; m_gnt = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd1) begin
      failures++; $display("FAIL basic_outstanding1 got=%0d exp=1", outstanding);
    end
    m_recv = 1'b1; i_ack = 1'b1; m_rdata = 32'h0000_0013; m_error = 1'b1;
    @(negedge g_clk);
    checks++;
    if ({i_recv, d_recv, m_ack} !== 3'b101) begin
      failures++; $display("FAIL basic_recv got=%b exp=101", {i_recv, d_recv, m_ack});
    end
    checks++;
    if ({rsp_error, rsp_rdata} !== {1'b1, 32'h0000_0013}) begin
      failures++; $display("FAIL basic_rsp got=%b/%h exp=1/00000013", rsp_error, rsp_rdata);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL basic_outstanding0 got=%0d exp=0", outstanding);
    end
  endtask

  task automatic test_streak();
    // Grant order D,D,D,D,I,D,D,D,D,I encoded with 1 = data, first grant in bit 9.
    logic [9:0] exp_order;
    exp_order = 10'b1111011110;
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_addr = 32'h0000_2000;
    m_gnt = 1'b1; m_recv = 1'b1; i_ack = 1'b1; d_ack = 1'b1;
    for (int k = 9; k >= 0; k--) begin
      @(negedge g_clk);
      checks++;
      if ({i_gnt, d_gnt} !== {~exp_order[k], exp_order[k]}) begin
        failures++;
        $display("FAIL streak_grant_%0d got i_gnt=%b d_gnt=%b exp_data=%b", 9 - k, i_gnt, d_gnt, exp_order[k]);
      end
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL streak_drain got=%0d exp=0", outstanding);
    end
  endtask

  task automatic test_stall();
    d_req = 1'b1; d_addr = 32'hA000_0040; d_wen = 1'b1; d_strb = 4'hC; d_wdata = 32'hDEAD_BEEF;
    i_addr = 32'h0000_0100;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) i_req = 1'b1;
      m_gnt = (c == 4) ? 1'b1 : 1'b0;
      @(negedge g_clk);
      checks++;
      if (m_addr !== 32'hA000_0040) begin
        failures++; $display("FAIL stall_addr_c%0d got=%h exp=a0000040", c, m_addr);
      end
      checks++;
      if ({i_gnt, d_gnt} !== {1'b0, (c == 4)}) begin
        failures++; $display("FAIL stall_gnt_c%0d got=%b%b exp=0%b", c, i_gnt, d_gnt, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if ({m_wen, m_strb, m_wdata} !== {1'b1, 4'hC, 32'hDEAD_BEEF}) begin
          failures++; $display("FAIL stall_wdata got=%b/%h/%h exp=1/c/deadbeef", m_wen, m_strb, m_wdata);
        end
      end
      next_cycle();
    end
    d_req = 1'b0; d_wen = 1'b0;
    @(negedge g_clk);
    checks++;
    if ({m_req, i_gnt, m_addr} !== {1'b1, 1'b1, 32'h0000_0100}) begin
      failures++; $display("FAIL stall_then_i got=%b%b/%h exp=11/00000100", m_req, i_gnt, m_addr);
    end
    next_cycle();
    i_req = 1'b0; m_gnt = 1'b0;
    m_recv = 1'b1; i_ack = 1'b1; d_ack = 1'b1;
    @(negedge g_clk);
    checks++;
    if ({i_recv, d_recv, m_ack} !== 3'b011) begin
      failures++; $display("FAIL stall_rsp1 got=%b exp=011", {i_recv, d_recv, m_ack});
    end
    next_cycle();
    @(negedge g_clk);
    checks++;
    if ({i_recv, d_recv, m_ack} !== 3'b101) begin
      failures++; $display("FAIL stall_rsp2 got=%b exp=101", {i_recv, d_recv, m_ack});
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL stall_drain got=%0d exp=0", outstanding);
    end
  endtask

  task automatic test_full();
    i_req = 1'b1; i_addr = 32'h0000_0200; m_gnt = 1'b1;
    next_cycle();
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h0000_0300;
    next_cycle();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0204;
    @(negedge g_clk);
    checks++;
    if ({outstanding, m_req, i_gnt} !== {3'd2, 1'b0, 1'b0}) begin
      failures++; $display("FAIL full_block got=%0d/%b%b exp=2/00", outstanding, m_req, i_gnt);
    end
    next_cycle();
    m_recv = 1'b1; i_ack = 1'b1;
    @(negedge g_clk);
    checks++;
    if ({i_recv, d_recv, m_ack, m_req, i_gnt} !== 5'b10100) begin
      failures++; $display("FAIL full_pop_no_push got=%b exp=10100", {i_recv, d_recv, m_ack, m_req, i_gnt});
    end
    next_cycle();
    i_ack = 1'b0; d_ack = 1'b1;
    @(negedge g_clk);
    checks++;
    if ({m_req, i_gnt, d_recv, i_recv, m_ack} !== 5'b11101) begin
      failures++; $display("FAIL full_regrant got=%b exp=11101", {m_req, i_gnt, d_recv, i_recv, m_ack});
    end
    checks++;
    if (outstanding !== 3'd1) begin
      failures++; $display("FAIL full_count_before got=%0d exp=1", outstanding);
    end
    next_cycle();
    m_recv = 1'b0; d_ack = 1'b0; i_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h0000_0304;
    next_cycle();
    d_req = 1'b0; m_gnt = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd2) begin
      failures++; $display("FAIL full_refill got=%0d exp=2", outstanding);
    end
  endtask

  task automatic test_async_reset();
    #2;
    g_reset = 1'b1;
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL async_reset_immediate got=%0d exp=0", outstanding);
    end
    next_cycle();
    g_reset = 1'b0;
    m_recv = 1'b1; i_ack = 1'b1; d_ack = 1'b1; m_rdata = 32'h1234_5678;
    @(negedge g_clk);
    checks++;
    if ({i_recv, d_recv, m_ack} !== 3'b000) begin
      failures++; $display("FAIL empty_recv got=%b exp=000", {i_recv, d_recv, m_ack});
    end
    checks++;
    if (rsp_rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL empty_rdata got=%h exp=12345678", rsp_rdata);
    end
    next_cycle();
    #1;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL empty_outstanding got=%0d exp=0", outstanding);
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    g_reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_streak();
    test_stall();
    test_full();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
